spi_cfg_master: RTL and testbench

Single-clock SPI master that serialises a parallel configuration word onto `sclk`/`sdi`/`cs_b` for the on-chip 8-bit configuration shift-register chain, and captures the previous chain contents returned on `sdo`. It sits in the FPGA/test-controller domain directly upstream of the configuration shift registers. Data goes MSB first, and `cs_b` rises at end of frame so the chain parallel-loads its `cfg` outputs.

---
 rtl/spi_cfg_pkg.sv | 18 +
 rtl/spi_tick_gen.sv | 29 ++
 rtl/spi_cfg_master.sv | 160 ++++++++++++++++
 tb/tb_spi_cfg_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared types and sizing helpers for the configuration-chain SPI master.
package spi_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_state_e;

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: one-cycle tick every CLK_DIV enabled cycles, restarted on clr.
module spi_tick_gen
  import spi_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DW = cnt_w(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_b || !en || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end

endmodule

// File: rtl/spi_cfg_master.sv
// SPI master for the 8-bit configuration shift-register chain: MSB-first shift-out,
// capture of the previous chain contents on sdo, cs_b rise parallel-loads the chain.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sclk,
  output logic             sdi,
  output logic             cs_b,
  input  logic             sdo
);

  localparam int unsigned BCW = cnt_w(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  spi_state_e       state;
  spi_state_e       state_nxt;
  logic             tick;
  logic             tick_en;
  logic             tick_clr;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [BCW-1:0]   bit_cnt;

  logic             sclk_nxt;
  logic             cs_b_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             ld_tx;
  logic             shift_tx;
  logic             sample_rx;
  logic             cnt_inc;
  logic             upd_rx;

  // The MSB of the tx register drives the line, so sdi only moves when it shifts (sclk falling).
  assign sdi = tx_sr[WIDTH-1];

  assign tick_en  = (state != IDLE);
  assign tick_clr = (state_nxt != state);

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_b (rst_b),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    sclk_nxt  = sclk;
    cs_b_nxt  = cs_b;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    ld_tx     = 1'b0;
    shift_tx  = 1'b0;
    sample_rx = 1'b0;
    cnt_inc   = 1'b0;
    upd_rx    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          ld_tx     = 1'b1;
          cs_b_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      SETUP, LOW: begin
        // sdo is taken on the same clk edge that raises sclk, i.e. before the chain shifts.
        if (tick) begin
          state_nxt = HIGH;
          sclk_nxt  = 1'b1;
          sample_rx = 1'b1;
        end
      end
      HIGH: begin
        if (tick) begin
          sclk_nxt = 1'b0;
          cnt_inc  = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = LOW;
            shift_tx  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_nxt = GAP;
          cs_b_nxt  = 1'b1;
          done_nxt  = 1'b1;
          upd_rx    = 1'b1;
        end
      end
      GAP: begin
        if (tick) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state   <= IDLE;
      sclk    <= 1'b0;
      cs_b    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      tx_sr   <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      sclk  <= sclk_nxt;
      cs_b  <= cs_b_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      if (ld_tx) begin
        tx_sr   <= tx_data;
        bit_cnt <= '0;
      end else begin
        if (shift_tx) begin
          tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
        end
        if (cnt_inc) begin
          bit_cnt <= bit_cnt + BCW'(1);
        end
      end
      if (upd_rx) begin
        rx_data <= rx_sr;
      end
    end
  end

  // Capture register is fully rewritten every frame before it is published.
  always_ff @(posedge clk) begin
    if (sample_rx) begin
      rx_sr <= {rx_sr[WIDTH-2:0], sdo};
    end
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: W=8/D=4 and W=16/D=1 instances driving behavioural chain models.
module tb_spi_cfg_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b;

  logic       start8;
  logic [7:0] tx8, rx8;
  logic       busy8, done8, sclk8, sdi8, cs_b8, sdo8;

  logic        start16;
  logic [15:0] tx16, rx16;
  logic        busy16, done16, sclk16, sdi16, cs_b16, sdo16;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_cfg_master #(.WIDTH(8), .CLK_DIV(4)) dut8 (
    .clk(clk), .rst_b(rst_b), .start(start8), .tx_data(tx8), .busy(busy8), .done(done8),
    .rx_data(rx8), .sclk(sclk8), .sdi(sdi8), .cs_b(cs_b8), .sdo(sdo8)
  );

  spi_cfg_master #(.WIDTH(16), .CLK_DIV(1)) dut16 (
    .clk(clk), .rst_b(rst_b), .start(start16), .tx_data(tx16), .busy(busy16), .done(done16),
    .rx_data(rx16), .sclk(sclk16), .sdi(sdi16), .cs_b(cs_b16), .sdo(sdo16)
  );

  // Single 8-bit chain segment behind dut8
  logic       ch8_load = 1'b0;
  logic [7:0] ch8_init = 8'h00;
  logic [7:0] ch8_sr, ch8_cfg;
  assign sdo8 = ch8_sr[7];
  always @(posedge sclk8 or posedge ch8_load)
    if (ch8_load) ch8_sr <= ch8_init;
    else          ch8_sr <= {ch8_sr[6:0], sdi8};
  always @(posedge cs_b8) ch8_cfg <= ch8_sr;

  // Two chained segments behind dut16: sdi -> up -> dn -> sdo
  logic        ch16_load = 1'b0;
  logic [15:0] ch16_init = 16'h0000;
  logic [7:0]  up_sr, dn_sr, up_cfg, dn_cfg;
  assign sdo16 = dn_sr[7];
  always @(posedge sclk16 or posedge ch16_load)
    if (ch16_load) begin
      dn_sr <= ch16_init[15:8];
      up_sr <= ch16_init[7:0];
    end else begin
      up_sr <= {up_sr[6:0], sdi16};
      dn_sr <= {dn_sr[6:0], up_sr[7]};
    end
  always @(posedge cs_b16) begin
    up_cfg <= up_sr;
    dn_cfg <= dn_sr;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_chain8(input logic [7:0] v);
    ch8_init = v;
    ch8_load = 1'b1;
    #1;
    ch8_load = 1'b0;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] init;
    logic [7:0] exp_rx;
    int         pulse_at;
  } vec_t;

  // One full W=8/D=4 frame, start raised after reference edge 0, observed for 120 cycles.
  task automatic run8(input vec_t v);
    int n, t_done, t_busy, t_rise0, t_fall, n_rise, n_done;
    logic [7:0] bits, rx_at_done;
    logic p_sclk, p_cs_b, p_sdi, viol;
    load_chain8(v.init);
    @(posedge clk); #1;
    tx8 = v.tx;
    start8 = 1'b1;
    t_done = -1; t_busy = -1; t_rise0 = -1; t_fall = -1;
    n_rise = 0; n_done = 0; bits = '0; rx_at_done = '0; viol = 1'b0;
    p_sclk = sclk8; p_cs_b = cs_b8; p_sdi = sdi8;
    for (n = 1; n <= 120; n++) begin
      @(posedge clk); #1;
      start8 = (v.pulse_at > 0) && (n == v.pulse_at);
      if (n == 1) tx8 = ~v.tx;
      if (!cs_b8 && p_cs_b && t_fall < 0) t_fall = n;
      if (sclk8 && !p_sclk) begin
        if (t_rise0 < 0) t_rise0 = n;
        n_rise++;
        bits = {bits[6:0], sdi8};
      end
      if (sclk8 && (sdi8 !== p_sdi)) viol = 1'b1;
      if ((cs_b8 !== p_cs_b) && (sclk8 || p_sclk)) viol = 1'b1;
      if (done8) begin
        n_done++;
        t_done = n;
        rx_at_done = rx8;
      end
      if (!busy8 && t_busy < 0) t_busy = n;
      p_sclk = sclk8; p_cs_b = cs_b8; p_sdi = sdi8;
    end
    chk("cs_fall_time", t_fall, 1);
    chk("first_rise_time", t_rise0, 5);
    chk("sclk_rise_count", n_rise, 8);
    chk("sdi_bits", bits, v.tx);
    chk("done_time", t_done, 69);
    chk("done_count", n_done, 1);
    chk("busy_fall_time", t_busy, 73);
    chk("rx_data", rx_at_done, v.exp_rx);
    chk("chain_cfg", ch8_cfg, v.tx);
    chk("line_rules", viol, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int n, falls, t_fall2, t_done1, t_done2, t_busy16, t_done16, rises16;
    logic [7:0] rx1, rx2, cfg1;
    logic [15:0] rx16_at_done;
    logic p_cs_b, p_sclk, seen_done;

    vecs[0] = '{tx: 8'hA5, init: 8'h3C, exp_rx: 8'h3C, pulse_at: 0};
    vecs[1] = '{tx: 8'h00, init: 8'hFF, exp_rx: 8'hFF, pulse_at: 0};
    vecs[2] = '{tx: 8'h81, init: 8'h7E, exp_rx: 8'h7E, pulse_at: 0};
    vecs[3] = '{tx: 8'h96, init: 8'hC3, exp_rx: 8'hC3, pulse_at: 20};
    vecs[4] = '{tx: 8'h5B, init: 8'hE1, exp_rx: 8'hE1, pulse_at: 0};

    rst_b = 1'b0;
    start8 = 1'b0; tx8 = '0;
    start16 = 1'b0; tx16 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b1;
    chk("rst_cs_b", cs_b8, 1);
    chk("rst_sclk", sclk8, 0);
    chk("rst_sdi", sdi8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_rx_data", rx8, 0);
    chk("rst16_cs_b", cs_b16, 1);
    chk("rst16_rx_data", rx16, 0);

    for (int i = 0; i < 4; i++) run8(vecs[i]);

    // Back-to-back frames with start held high
    load_chain8(8'h5A);
    @(posedge clk); #1;
    tx8 = 8'hFF; start8 = 1'b1;
    p_cs_b = cs_b8; falls = 0;
    t_fall2 = -1; t_done1 = -1; t_done2 = -1;
    rx1 = '0; rx2 = '0; cfg1 = '0;
    for (n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 1) tx8 = 8'h00;
      if (!cs_b8 && p_cs_b) begin
        falls++;
        if (falls == 2) begin
          t_fall2 = n;
          start8 = 1'b0;
        end
      end
      if (done8) begin
        if (t_done1 < 0) begin
          t_done1 = n; rx1 = rx8; cfg1 = ch8_cfg;
        end else if (t_done2 < 0) begin
          t_done2 = n; rx2 = rx8;
        end
      end
      p_cs_b = cs_b8;
      if (t_done2 > 0 && !busy8) break;
    end
    start8 = 1'b0;
    chk("b2b_done1_time", t_done1, 69);
    chk("b2b_rx1", rx1, 8'h5A);
    chk("b2b_cfg1", cfg1, 8'hFF);
    chk("b2b_cs_fall2_time", t_fall2, 74);
    chk("b2b_done2_time", t_done2, 142);
    chk("b2b_rx2", rx2, 8'hFF);
    chk("b2b_cfg2", ch8_cfg, 8'h00);
    repeat (3) @(posedge clk);

    // Reset in the middle of a frame
    load_chain8(8'h00);
    @(posedge clk); #1;
    tx8 = 8'hC7; start8 = 1'b1;
    seen_done = 1'b0;
    for (n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (n == 1) start8 = 1'b0;
      if (done8) seen_done = 1'b1;
    end
    chk("midrst_cs_low_before", cs_b8, 0);
    chk("midrst_busy_before", busy8, 1);
    rst_b = 1'b0;
    @(posedge clk); #1;
    chk("midrst_cs_b", cs_b8, 1);
    chk("midrst_sclk", sclk8, 0);
    chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8 | seen_done, 0);
    rst_b = 1'b1;
    @(posedge clk); #1;
    run8(vecs[4]);

    // W=16, D=1 across two chain segments
    ch16_init = 16'h9EC3;
    ch16_load = 1'b1; #1; ch16_load = 1'b0;
    @(posedge clk); #1;
    tx16 = 16'h1234; start16 = 1'b1;
    t_done16 = -1; t_busy16 = -1; rises16 = 0; rx16_at_done = '0;
    p_sclk = sclk16;
    for (n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        start16 = 1'b0;
        tx16 = 16'hFFFF;
      end
      if (sclk16 && !p_sclk) rises16++;
      if (done16 && t_done16 < 0) begin
        t_done16 = n; rx16_at_done = rx16;
      end
      if (!busy16 && t_busy16 < 0) t_busy16 = n;
      p_sclk = sclk16;
    end
    chk("w16_done_time", t_done16, 34);
    chk("w16_busy_fall_time", t_busy16, 35);
    chk("w16_rise_count", rises16, 16);
    chk("w16_up_cfg", up_cfg, 8'h34);
    chk("w16_dn_cfg", dn_cfg, 8'h12);
    chk("w16_rx_data", rx16_at_done, 16'h9EC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
